// File: rtl/prepare_ctrl_if.sv
// ============================================================================
// Module      : prepare_ctrl_if
// Description : Handshake and strobe bundle between prepare_ctrl and its
//               surrounding manage / state / log / UDP blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prepare_ctrl_if;
   logic manage_prep_req_val;
   logic manage_prep_req_last;
   logic prep_manage_req_rdy;
   logic ctrl_datap_store_info;
   logic prep_vr_state_rd_req_val;
   logic vr_state_prep_rd_req_rdy;
   logic vr_state_prep_rd_resp_val;
   logic prep_vr_state_rd_resp_rdy;
   logic prep_log_hdr_mem_rd_req_val;
   logic clean_ctrl_datap_store_hdr;
   logic datap_ctrl_prep_ok;
   logic datap_ctrl_log_has_space;
   logic prep_log_data_mem_wr_val;
   logic log_ctrl_datap_incr_wr_addr;
   logic prep_log_hdr_mem_wr_val;
   logic prep_vr_state_wr_req_val;
   logic vr_state_prep_wr_req_rdy;
   logic prep_to_udp_meta_val;
   logic udp_prep_meta_rdy;
   logic prep_to_udp_data_val;
   logic udp_prep_data_rdy;

   modport master (
      input  manage_prep_req_val, manage_prep_req_last,
      output prep_manage_req_rdy, ctrl_datap_store_info,
      output prep_vr_state_rd_req_val,
      input  vr_state_prep_rd_req_rdy, vr_state_prep_rd_resp_val,
      output prep_vr_state_rd_resp_rdy,
      output prep_log_hdr_mem_rd_req_val, clean_ctrl_datap_store_hdr,
      input  datap_ctrl_prep_ok, datap_ctrl_log_has_space,
      output prep_log_data_mem_wr_val, log_ctrl_datap_incr_wr_addr,
      output prep_log_hdr_mem_wr_val, prep_vr_state_wr_req_val,
      input  vr_state_prep_wr_req_rdy,
      output prep_to_udp_meta_val,
      input  udp_prep_meta_rdy,
      output prep_to_udp_data_val,
      input  udp_prep_data_rdy
   );

   modport slave (
      output manage_prep_req_val, manage_prep_req_last,
      input  prep_manage_req_rdy, ctrl_datap_store_info,
      input  prep_vr_state_rd_req_val,
      output vr_state_prep_rd_req_rdy, vr_state_prep_rd_resp_val,
      input  prep_vr_state_rd_resp_rdy,
      input  prep_log_hdr_mem_rd_req_val, clean_ctrl_datap_store_hdr,
      output datap_ctrl_prep_ok, datap_ctrl_log_has_space,
      input  prep_log_data_mem_wr_val, log_ctrl_datap_incr_wr_addr,
      input  prep_log_hdr_mem_wr_val, prep_vr_state_wr_req_val,
      output vr_state_prep_wr_req_rdy,
      input  prep_to_udp_meta_val,
      output udp_prep_meta_rdy,
      input  prep_to_udp_data_val,
      output udp_prep_data_rdy
   );
endinterface

`default_nettype wire

// File: rtl/prepare_ctrl.sv
// ============================================================================
// Module      : prepare_ctrl
// Description : Control FSM sequencing the VR Prepare datapath, one message
//               at a time. Optional PREP_CTRL_STATS_EN adds ok/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prepare_ctrl #(
   parameter int NOC_DATA_W = 512
) (
   input  logic        clk,
   input  logic        rst,
   prepare_ctrl_if.master bus
`ifdef PREP_CTRL_STATS_EN
   ,
   output logic [31:0] prep_ok_cnt,
   output logic [31:0] prep_drop_cnt
`endif
);

   if (NOC_DATA_W <= 0 || (NOC_DATA_W % 8) != 0) begin : g_bad_width
      $error("prepare_ctrl: NOC_DATA_W must be a positive multiple of 8");
   end

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_RD_STATE   = 4'd1,
      ST_STATE_RESP = 4'd2,
      ST_HDR_RD     = 4'd3,
      ST_HDR_STORE  = 4'd4,
      ST_CHECK      = 4'd5,
      ST_WR_DATA    = 4'd6,
      ST_COMMIT     = 4'd7,
      ST_SEND_META  = 4'd8,
      ST_SEND_DATA  = 4'd9,
      ST_DRAIN      = 4'd10
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_hdr_last;
   logic   r_out_en;
   logic   w_hdr_fire;
   logic   w_accept;

   // Ready stays low through reset and for the first cycle after release.
   assign w_hdr_fire = (r_state == ST_IDLE) & r_out_en & bus.manage_prep_req_val;
   assign w_accept   = bus.datap_ctrl_prep_ok & bus.datap_ctrl_log_has_space;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hdr_last <= 1'b0;
         r_out_en   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_out_en <= 1'b1;
         if (w_hdr_fire) begin
            r_hdr_last <= bus.manage_prep_req_last;
         end
      end
   end

   always_comb begin
      w_next                          = r_state;
      bus.prep_manage_req_rdy         = 1'b0;
      bus.ctrl_datap_store_info       = 1'b0;
      bus.prep_vr_state_rd_req_val    = 1'b0;
      bus.prep_vr_state_rd_resp_rdy   = 1'b0;
      bus.prep_log_hdr_mem_rd_req_val = 1'b0;
      bus.clean_ctrl_datap_store_hdr  = 1'b0;
      bus.prep_log_data_mem_wr_val    = 1'b0;
      bus.log_ctrl_datap_incr_wr_addr = 1'b0;
      bus.prep_log_hdr_mem_wr_val     = 1'b0;
      bus.prep_vr_state_wr_req_val    = 1'b0;
      bus.prep_to_udp_meta_val        = 1'b0;
      bus.prep_to_udp_data_val        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.prep_manage_req_rdy = r_out_en;
            if (w_hdr_fire) begin
               bus.ctrl_datap_store_info = 1'b1;
               w_next                    = ST_RD_STATE;
            end
         end
         ST_RD_STATE: begin
            bus.prep_vr_state_rd_req_val = 1'b1;
            if (bus.vr_state_prep_rd_req_rdy) w_next = ST_STATE_RESP;
         end
         // Response stays un-acked so its data remains stable for the datapath.
         ST_STATE_RESP: begin
            if (bus.vr_state_prep_rd_resp_val) w_next = ST_HDR_RD;
         end
         ST_HDR_RD: begin
            bus.prep_log_hdr_mem_rd_req_val = 1'b1;
            w_next                          = ST_HDR_STORE;
         end
         ST_HDR_STORE: begin
            bus.clean_ctrl_datap_store_hdr = 1'b1;
            w_next                         = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_accept) begin
               w_next = r_hdr_last ? ST_COMMIT : ST_WR_DATA;
            end else if (r_hdr_last) begin
               bus.prep_vr_state_rd_resp_rdy = 1'b1;
               w_next                        = ST_IDLE;
            end else begin
               w_next = ST_DRAIN;
            end
         end
         ST_WR_DATA: begin
            bus.prep_manage_req_rdy = 1'b1;
            if (bus.manage_prep_req_val) begin
               bus.prep_log_data_mem_wr_val    = 1'b1;
               bus.log_ctrl_datap_incr_wr_addr = 1'b1;
               if (bus.manage_prep_req_last) w_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            bus.prep_vr_state_wr_req_val = 1'b1;
            if (bus.vr_state_prep_wr_req_rdy) begin
               bus.prep_log_hdr_mem_wr_val   = 1'b1;
               bus.prep_vr_state_rd_resp_rdy = 1'b1;
               w_next                        = ST_SEND_META;
            end
         end
         ST_SEND_META: begin
            bus.prep_to_udp_meta_val = 1'b1;
            if (bus.udp_prep_meta_rdy) w_next = ST_SEND_DATA;
         end
         ST_SEND_DATA: begin
            bus.prep_to_udp_data_val = 1'b1;
            if (bus.udp_prep_data_rdy) w_next = ST_IDLE;
         end
         ST_DRAIN: begin
            bus.prep_manage_req_rdy = 1'b1;
            if (bus.manage_prep_req_val && bus.manage_prep_req_last) begin
               bus.prep_vr_state_rd_resp_rdy = 1'b1;
               w_next                        = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef PREP_CTRL_STATS_EN
   logic        w_ok_fire;
   logic        w_drop;
   logic [31:0] r_ok_cnt;
   logic [31:0] r_drop_cnt;

   assign w_ok_fire = (r_state == ST_SEND_DATA) & bus.udp_prep_data_rdy;
   assign w_drop    = (r_state == ST_CHECK) & ~w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ok_cnt   <= 32'd0;
         r_drop_cnt <= 32'd0;
      end else begin
         if (w_ok_fire) r_ok_cnt <= r_ok_cnt + 32'd1;
         if (w_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign prep_ok_cnt   = r_ok_cnt;
   assign prep_drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prepare_ctrl.sv
// ============================================================================
// Module      : tb_prepare_ctrl
// Description : Randomised self-checking bench for prepare_ctrl with a
//               message-level expectation model and per-cycle protocol checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prepare_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   // Driver-owned stimulus knobs
   int   w_rd, w_wr, w_meta, w_data, d_resp;
   bit   hdr_line, accept;
   int   m_ok, m_drop;

   // Monitor-owned observations for the current message
   int   cyc;
   int   n_lines, n_rd, n_hrd, n_sh, n_resp, n_dwr, n_incr, n_hwr, n_swr;
   int   n_meta, n_udp, n_wrv_cyc, n_metav_cyc;
   int   hdr_cyc, sh_cyc, resp_cyc, meta_cyc;

   prepare_ctrl_if bus ();

`ifdef PREP_CTRL_STATS_EN
   logic [31:0] ok_cnt;
   logic [31:0] drop_cnt;
`endif

   prepare_ctrl #(.NOC_DATA_W(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PREP_CTRL_STATS_EN
      ,
      .prep_ok_cnt   (ok_cnt),
      .prep_drop_cnt (drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int outs();
      return int'({bus.prep_manage_req_rdy, bus.ctrl_datap_store_info,
                   bus.prep_vr_state_rd_req_val, bus.prep_vr_state_rd_resp_rdy,
                   bus.prep_log_hdr_mem_rd_req_val, bus.clean_ctrl_datap_store_hdr,
                   bus.prep_log_data_mem_wr_val, bus.log_ctrl_datap_incr_wr_addr,
                   bus.prep_log_hdr_mem_wr_val, bus.prep_vr_state_wr_req_val,
                   bus.prep_to_udp_meta_val, bus.prep_to_udp_data_val});
   endfunction

   // Environment: state-memory and UDP responders with programmable waits
   initial begin
      int c_rd, c_wr, c_meta, c_data, c_resp;
      bit pend, rd_v, rd_f, wr_v, wr_f, meta_v, meta_f, data_v, data_f, resp_f;
      c_rd = 0; c_wr = 0; c_meta = 0; c_data = 0; c_resp = 0; pend = 0;
      bus.vr_state_prep_rd_resp_val = 1'b0;
      bus.vr_state_prep_rd_req_rdy  = 1'b1;
      bus.vr_state_prep_wr_req_rdy  = 1'b1;
      bus.udp_prep_meta_rdy         = 1'b1;
      bus.udp_prep_data_rdy         = 1'b1;
      forever begin
         @(negedge clk);
         rd_v   = bus.prep_vr_state_rd_req_val;
         rd_f   = rd_v & bus.vr_state_prep_rd_req_rdy;
         wr_v   = bus.prep_vr_state_wr_req_val;
         wr_f   = wr_v & bus.vr_state_prep_wr_req_rdy;
         meta_v = bus.prep_to_udp_meta_val;
         meta_f = meta_v & bus.udp_prep_meta_rdy;
         data_v = bus.prep_to_udp_data_val;
         data_f = data_v & bus.udp_prep_data_rdy;
         resp_f = bus.vr_state_prep_rd_resp_val & bus.prep_vr_state_rd_resp_rdy;
         @(posedge clk);
         #1;
         if (rst) begin
            c_rd = 0; c_wr = 0; c_meta = 0; c_data = 0; c_resp = 0; pend = 0;
            bus.vr_state_prep_rd_resp_val = 1'b0;
         end else begin
            if (rd_f) begin c_rd = 0; pend = 1; c_resp = 0; end
            else if (rd_v) c_rd++;
            if (wr_f) c_wr = 0; else if (wr_v) c_wr++;
            if (meta_f) c_meta = 0; else if (meta_v) c_meta++;
            if (data_f) c_data = 0; else if (data_v) c_data++;
            if (resp_f) begin
               bus.vr_state_prep_rd_resp_val = 1'b0;
               pend = 0;
            end else if (pend && !bus.vr_state_prep_rd_resp_val) begin
               if (c_resp >= d_resp) bus.vr_state_prep_rd_resp_val = 1'b1;
               else c_resp++;
            end
         end
         bus.vr_state_prep_rd_req_rdy = (c_rd >= w_rd);
         bus.vr_state_prep_wr_req_rdy = (c_wr >= w_wr);
         bus.udp_prep_meta_rdy        = (c_meta >= w_meta);
         bus.udp_prep_data_rdy        = (c_data >= w_data);
      end
   end

   // Compare process: per-cycle checks and per-message event tallies
   initial begin
      bit fire, p_meta, p_data, p_wr, p_rd, p_hrd;
      p_meta = 0; p_data = 0; p_wr = 0; p_rd = 0; p_hrd = 0;
      cyc = 0; hdr_cyc = 0; sh_cyc = -1; resp_cyc = -1; meta_cyc = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            p_meta = 0; p_data = 0; p_wr = 0; p_rd = 0; p_hrd = 0;
         end else begin
            fire = bus.manage_prep_req_val & bus.prep_manage_req_rdy;
            if (fire && hdr_line) begin
               n_lines = 0; n_rd = 0; n_hrd = 0; n_sh = 0; n_resp = 0; n_dwr = 0;
               n_incr = 0; n_hwr = 0; n_swr = 0; n_meta = 0; n_udp = 0;
               n_wrv_cyc = 0; n_metav_cyc = 0;
               hdr_cyc = cyc; sh_cyc = -1; resp_cyc = -1; meta_cyc = -1;
            end
            check("store_info", int'(bus.ctrl_datap_store_info), int'(fire & hdr_line));
            check("data_wr", int'(bus.prep_log_data_mem_wr_val), int'(fire & ~hdr_line & accept));
            check("incr_wr_addr", int'(bus.log_ctrl_datap_incr_wr_addr), int'(fire & ~hdr_line & accept));
            check("hdr_wr_vs_state_wr_fire", int'(bus.prep_log_hdr_mem_wr_val),
                  int'(bus.prep_vr_state_wr_req_val & bus.vr_state_prep_wr_req_rdy));
            check("resp_rdy_without_val",
                  int'(bus.prep_vr_state_rd_resp_rdy & ~bus.vr_state_prep_rd_resp_val), 0);
            if (p_meta) check("meta_val_held", int'(bus.prep_to_udp_meta_val), 1);
            if (p_data) check("data_val_held", int'(bus.prep_to_udp_data_val), 1);
            if (p_wr) check("state_wr_val_held", int'(bus.prep_vr_state_wr_req_val), 1);
            if (p_rd) check("state_rd_val_held", int'(bus.prep_vr_state_rd_req_val), 1);
            if (bus.clean_ctrl_datap_store_hdr) begin
               check("hdr_rd_before_store", int'(p_hrd), 1);
               n_sh++;
               sh_cyc = cyc;
            end
            if (fire && !hdr_line)
               check("payload_after_check", int'(n_sh == 1 && cyc > sh_cyc + 1), 1);
            if (fire) n_lines++;
            if (bus.prep_vr_state_rd_req_val && bus.vr_state_prep_rd_req_rdy) n_rd++;
            if (bus.prep_log_hdr_mem_rd_req_val) n_hrd++;
            if (bus.vr_state_prep_rd_resp_val && bus.prep_vr_state_rd_resp_rdy) begin
               n_resp++;
               resp_cyc = cyc;
            end
            if (bus.prep_log_data_mem_wr_val) n_dwr++;
            if (bus.log_ctrl_datap_incr_wr_addr) n_incr++;
            if (bus.prep_log_hdr_mem_wr_val) n_hwr++;
            if (bus.prep_vr_state_wr_req_val) n_wrv_cyc++;
            if (bus.prep_vr_state_wr_req_val && bus.vr_state_prep_wr_req_rdy) n_swr++;
            if (bus.prep_to_udp_meta_val) begin
               n_metav_cyc++;
               if (meta_cyc < 0) meta_cyc = cyc;
            end
            if (bus.prep_to_udp_meta_val && bus.udp_prep_meta_rdy) n_meta++;
            if (bus.prep_to_udp_data_val && bus.udp_prep_data_rdy) n_udp++;
            p_meta = bus.prep_to_udp_meta_val & ~bus.udp_prep_meta_rdy;
            p_data = bus.prep_to_udp_data_val & ~bus.udp_prep_data_rdy;
            p_wr   = bus.prep_vr_state_wr_req_val & ~bus.vr_state_prep_wr_req_rdy;
            p_rd   = bus.prep_vr_state_rd_req_val & ~bus.vr_state_prep_rd_req_rdy;
            p_hrd  = bus.prep_log_hdr_mem_rd_req_val;
         end
      end
   end

   task automatic send_line(input bit hdr, input bit last);
      int t;
      bit got;
      t = 0; got = 0;
      hdr_line = hdr;
      bus.manage_prep_req_val  = 1'b1;
      bus.manage_prep_req_last = last;
      while (!got && t < 200) begin
         @(negedge clk);
         if (bus.prep_manage_req_rdy) got = 1;
         else t++;
      end
      if (!got) check("line_accept_timeout", t, 0);
      @(posedge clk);
      #1;
      bus.manage_prep_req_val  = 1'b0;
      bus.manage_prep_req_last = 1'b0;
      hdr_line = 1'b0;
   endtask

   // Message-level model: what a message of n payload lines must produce
   task automatic run_msg(input int n, input bit ok, input bit sp, input int wrd, input int wwr,
                          input int wmeta, input int wdata, input int dresp, input bit bub);
      bit acc;
      int t;
      acc = ok & sp;
      w_rd = wrd; w_wr = wwr; w_meta = wmeta; w_data = wdata; d_resp = dresp;
      accept = acc;
      bus.datap_ctrl_prep_ok       = ok;
      bus.datap_ctrl_log_has_space = sp;
      send_line(1'b1, n == 0);
      for (int i = 0; i < n; i++) begin
         if (bub && $urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
         send_line(1'b0, i == n - 1);
      end
      t = 0;
      while (!(acc ? (n_udp == 1) : (n_resp == 1)) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) check("msg_complete_timeout", t, 0);
      if (acc) m_ok++; else m_drop++;
      check("lines_accepted", n_lines, n + 1);
      check("state_rd_fires", n_rd, 1);
      check("hdr_mem_rd", n_hrd, 1);
      check("store_hdr", n_sh, 1);
      check("resp_rdy_pulses", n_resp, 1);
      check("data_writes", n_dwr, acc ? n : 0);
      check("incr_pulses", n_incr, acc ? n : 0);
      check("hdr_writes", n_hwr, acc ? 1 : 0);
      check("state_writes", n_swr, acc ? 1 : 0);
      check("udp_meta", n_meta, acc ? 1 : 0);
      check("udp_data", n_udp, acc ? 1 : 0);
      @(negedge clk);
      check("idle_rdy", int'(bus.prep_manage_req_rdy), 1);
`ifdef PREP_CTRL_STATS_EN
      check("prep_ok_cnt", int'(ok_cnt), m_ok);
      check("prep_drop_cnt", int'(drop_cnt), m_drop);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1'b1;
      hdr_line = 0; accept = 0; m_ok = 0; m_drop = 0;
      w_rd = 0; w_wr = 0; w_meta = 0; w_data = 0; d_resp = 0;
      bus.manage_prep_req_val      = 1'b0;
      bus.manage_prep_req_last     = 1'b0;
      bus.datap_ctrl_prep_ok       = 1'b0;
      bus.datap_ctrl_log_has_space = 1'b0;
      #2;
      check("reset_outputs", outs(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_reset_rdy", int'(bus.prep_manage_req_rdy), 1);
      check("post_reset_other_outputs", outs() & 'h7FF, 0);
`ifdef PREP_CTRL_STATS_EN
      check("reset_ok_cnt", int'(ok_cnt), 0);
      check("reset_drop_cnt", int'(drop_cnt), 0);
`endif
      @(posedge clk);
      #1;

      // Header + 3 payload lines, accepted, zero-wait
      run_msg(3, 1, 1, 0, 0, 0, 0, 0, 0);
      check("dir_accept_data_writes", n_dwr, 3);
      check("dir_accept_incr", n_incr, 3);
`ifdef PREP_CTRL_STATS_EN
      check("dir_ok_cnt_one", int'(ok_cnt), 1);
`endif

      // ok=0 with 4 payload lines: drained silently
      run_msg(4, 0, 1, 0, 0, 0, 0, 0, 0);
      check("dir_drain_lines", n_lines, 5);
      check("dir_drain_no_writes", n_dwr + n_hwr + n_swr + n_meta + n_udp, 0);
`ifdef PREP_CTRL_STATS_EN
      check("dir_drop_cnt_one", int'(drop_cnt), 1);
`endif

      // Header-only accepted: meta_val 7 cycles after the header fire
      run_msg(0, 1, 1, 0, 0, 0, 0, 0, 0);
      check("dir_hdr_only_latency", meta_cyc - hdr_cyc, 7);
      check("dir_hdr_only_no_data", n_dwr, 0);

      // Header-only, no space: resp_rdy pulses in the cycle after HDR_STORE
      run_msg(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("dir_nospace_resp_in_check", resp_cyc - sh_cyc, 1);

      // Backpressure: state write waits 5 cycles, meta waits 3
      run_msg(2, 1, 1, 0, 5, 3, 0, 0, 0);
      check("dir_bp_wr_val_cycles", n_wrv_cyc, 6);
      check("dir_bp_meta_val_cycles", n_metav_cyc, 4);

      // Reset during WR_DATA after 2 of 5 lines
      w_rd = 0; w_wr = 0; w_meta = 0; w_data = 0; d_resp = 0;
      accept = 1;
      bus.datap_ctrl_prep_ok       = 1'b1;
      bus.datap_ctrl_log_has_space = 1'b1;
      send_line(1'b1, 1'b0);
      send_line(1'b0, 1'b0);
      send_line(1'b0, 1'b0);
      bus.manage_prep_req_val = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", outs(), 0);
      bus.manage_prep_req_val = 1'b0;
      m_ok = 0; m_drop = 0;
      repeat (2) begin
         @(negedge clk);
         check("in_reset_outputs", outs(), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("after_reset_rdy", int'(bus.prep_manage_req_rdy), 1);
      check("after_reset_other_outputs", outs() & 'h7FF, 0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 30; k++) begin
         run_msg($urandom_range(0, 4), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
